// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp constants and phase sequencing helpers for traffic_signal.
// Optional macro TRAFFIC_PED_PHASE_EN enables the pedestrian all-red phase S8.
package traffic_pkg;

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8
  } phase_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      S4:      return S5;
      S5:      return S6;
      S6:      return S7;
`ifdef TRAFFIC_PED_PHASE_EN
      S7:      return S8;
`else
      S7:      return S0;
`endif
      default: return S0;
    endcase
  endfunction

  // S8 is unreachable without the pedestrian phase; the top treats it as illegal.
  function automatic logic [5:0] phase_duration(input phase_t p,
                                                input int unsigned t_main,
                                                input int unsigned t_left,
                                                input int unsigned t_yel,
                                                input int unsigned t_ped);
    case (p)
      S0, S4:         return 6'(t_main);
      S2, S6:         return 6'(t_left);
      S1, S3, S5, S7: return 6'(t_yel);
      S8:             return 6'(t_ped);
      default:        return 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/traffic_signal_phase_timer.sv
// 5-bit phase timer: counts elapsed cycles, clears on terminal count or abort.
module phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] last,
  input  logic       abort,
  output logic [4:0] count,
  output logic       phase_done
);

  assign phase_done = abort | (count == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (phase_done) begin
      count <= '0;
    end else begin
      count <= count + 5'd1;
    end
  end

endmodule

// File: rtl/traffic_signal.sv
// Fixed-time four-way crossroad controller (Moore FSM plus phase timer).
// Optional macro TRAFFIC_PED_PHASE_EN adds the pedestrian all-red phase.
module traffic_signal
  import traffic_pkg::*;
#(
  parameter int unsigned T_MAIN = 7,
  parameter int unsigned T_LEFT = 5,
  parameter int unsigned T_YEL  = 2,
  parameter int unsigned T_PED  = 5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] count,
  output logic [2:0] signal_M1,
  output logic [2:0] signal_M2,
  output logic [2:0] signal_M3,
  output logic [2:0] signal_M4,
  output logic [2:0] signal_L1,
  output logic [2:0] signal_L2,
  output logic [2:0] signal_L3,
  output logic [2:0] signal_L4,
  output logic       signal_pedestrian
);

  phase_t     state_q;
  phase_t     state_d;
  logic [5:0] dur;
  logic [4:0] last;
  logic       illegal;
  logic       phase_done;

`ifdef TRAFFIC_PED_PHASE_EN
  assign illegal = (state_q > S8);
`else
  assign illegal = (state_q > S7);
`endif

  assign dur  = phase_duration(state_q, T_MAIN, T_LEFT, T_YEL, T_PED);
  assign last = 5'(dur - 6'd1);

  // Illegal encodings abort so the next edge lands in S0 with count cleared.
  phase_timer u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .last       (last),
    .abort      (illegal),
    .count      (count),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (phase_done) begin
      state_d = illegal ? S0 : next_phase(state_q);
    end
  end

  always_comb begin
    signal_M1         = RED;
    signal_M2         = RED;
    signal_M3         = RED;
    signal_M4         = RED;
    signal_L1         = RED;
    signal_L2         = RED;
    signal_L3         = RED;
    signal_L4         = RED;
    signal_pedestrian = 1'b0;
    case (state_q)
      S0: begin signal_M1 = GREEN;  signal_M2 = GREEN;  end
      S1: begin signal_M1 = YELLOW; signal_M2 = YELLOW; end
      S2: begin signal_L1 = GREEN;  signal_L2 = GREEN;  end
      S3: begin signal_L1 = YELLOW; signal_L2 = YELLOW; end
      S4: begin signal_M3 = GREEN;  signal_M4 = GREEN;  end
      S5: begin signal_M3 = YELLOW; signal_M4 = YELLOW; end
      S6: begin signal_L3 = GREEN;  signal_L4 = GREEN;  end
      S7: begin signal_L3 = YELLOW; signal_L4 = YELLOW; end
`ifdef TRAFFIC_PED_PHASE_EN
      S8: signal_pedestrian = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_signal.sv
// Directed self-checking bench for traffic_signal with default durations.
module tb_traffic_signal;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

`ifdef TRAFFIC_PED_PHASE_EN
  localparam int NPH    = 9;
  localparam int PERIOD = 37;
`else
  localparam int NPH    = 8;
  localparam int PERIOD = 32;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] count;
  logic [2:0] signal_M1, signal_M2, signal_M3, signal_M4;
  logic [2:0] signal_L1, signal_L2, signal_L3, signal_L4;
  logic       signal_pedestrian;

  int total = 0;
  int bad   = 0;
  int entry [9] = '{0, 7, 9, 14, 16, 23, 25, 30, 32};

  traffic_signal #(.T_MAIN(7), .T_LEFT(5), .T_YEL(2), .T_PED(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .count             (count),
    .signal_M1         (signal_M1),
    .signal_M2         (signal_M2),
    .signal_M3         (signal_M3),
    .signal_M4         (signal_M4),
    .signal_L1         (signal_L1),
    .signal_L2         (signal_L2),
    .signal_L3         (signal_L3),
    .signal_L4         (signal_L4),
    .signal_pedestrian (signal_pedestrian)
  );

  always #5 clk = ~clk;

  // {M1,M2,M3,M4,L1,L2,L3,L4,ped}
  function automatic logic [24:0] exp_lamps(input int p);
    case (p)
      0: return {G, G, R, R, R, R, R, R, 1'b0};
      1: return {Y, Y, R, R, R, R, R, R, 1'b0};
      2: return {R, R, R, R, G, G, R, R, 1'b0};
      3: return {R, R, R, R, Y, Y, R, R, 1'b0};
      4: return {R, R, G, G, R, R, R, R, 1'b0};
      5: return {R, R, Y, Y, R, R, R, R, 1'b0};
      6: return {R, R, R, R, R, R, G, G, 1'b0};
      7: return {R, R, R, R, R, R, Y, Y, 1'b0};
      default: return {R, R, R, R, R, R, R, R, 1'b1};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = number of edges since reset release
  task automatic check_at(input int n, input string tag);
    int pos, ph;
    logic [24:0] obs, exp_l;
    logic [4:0] exp_c;
    logic g12, g34;
    pos = n % PERIOD;
    ph = 0;
    for (int i = 0; i < NPH; i++) if (pos >= entry[i]) ph = i;
    exp_c = 5'(pos - entry[ph]);
    exp_l = exp_lamps(ph);
    obs = {signal_M1, signal_M2, signal_M3, signal_M4,
           signal_L1, signal_L2, signal_L3, signal_L4, signal_pedestrian};

    total++;
    assert (count === exp_c) else begin
      bad++;
      $error("FAIL %s count n=%0d observed=%0d expected=%0d", tag, n, count, exp_c);
    end
    total++;
    assert (obs === exp_l) else begin
      bad++;
      $error("FAIL %s lamps n=%0d observed=%b expected=%b", tag, n, obs, exp_l);
    end

    g12 = (signal_M1 != R) || (signal_M2 != R) || (signal_L1 != R) || (signal_L2 != R);
    g34 = (signal_M3 != R) || (signal_M4 != R) || (signal_L3 != R) || (signal_L4 != R);
    total++;
    assert ($onehot(signal_M1) && $onehot(signal_M2) && $onehot(signal_M3) && $onehot(signal_M4) &&
            $onehot(signal_L1) && $onehot(signal_L2) && $onehot(signal_L3) && $onehot(signal_L4))
    else begin
      bad++;
      $error("FAIL %s onehot n=%0d observed=%b expected=one-hot lamps", tag, n, obs);
    end
    total++;
    assert (!(g12 && g34) &&
            !((signal_M1 != R) && (signal_L1 != R)) && !((signal_M2 != R) && (signal_L2 != R)) &&
            !((signal_M3 != R) && (signal_L3 != R)) && !((signal_M4 != R) && (signal_L4 != R)))
    else begin
      bad++;
      $error("FAIL %s conflict n=%0d observed=%b expected=conflict-free", tag, n, obs);
    end
    total++;
    assert (!signal_pedestrian || !(g12 || g34)) else begin
      bad++;
      $error("FAIL %s ped_safe n=%0d observed=%b expected=all red with ped", tag, n, obs);
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    // Asynchronous reset away from the clock edge must act immediately.
    #3 reset = 1'b0;
    #1 check_at(0, "async_reset");
    @(negedge clk);
    reset = 1'b1;
    #1 check_at(0, "release");

    for (int n = 1; n <= 150; n++) begin
      step();
      check_at(n, "run");
    end

    // Restart, then abort in S4 at edge 20 (count=4).
    @(negedge clk);
    reset = 1'b0;
    #1 check_at(0, "reset2");
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      check_at(n, "pre_abort");
    end
    total++;
    assert (count === 5'd4 && signal_M3 === G) else begin
      bad++;
      $error("FAIL mid_s4 observed count=%0d M3=%b expected count=4 M3=001", count, signal_M3);
    end
    #2 reset = 1'b0;
    #1 check_at(0, "abort_s4");
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      check_at(n, "post_abort");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/traffic_signal.md
Name: traffic_signal

Overview:
- Fixed-time controller for a four-way crossroad.
- Four approaches, each with a main (straight) signal M1–M4 and a protected left-turn signal L1–L4, plus an all-red pedestrian phase.
- A Moore FSM sequences the phases; a 5-bit phase timer exposes elapsed cycles in the current phase.
- Stand-alone top-level block driving lamp drivers.

Parameters:
- T_MAIN, 7, cycles a main-green phase lasts (legal 1..32)
- T_LEFT, 5, cycles a left-green phase lasts (legal 1..32)
- T_YEL, 2, cycles any yellow phase lasts (legal 1..32)
- T_PED, 5, cycles the pedestrian all-red phase lasts (legal 1..32)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- count  output  5  elapsed cycles in current phase, 0 at phase entry
- signal_M1  output  3  main signal approach 1
- signal_M2  output  3  main signal approach 2
- signal_M3  output  3  main signal approach 3
- signal_M4  output  3  main signal approach 4
- signal_L1  output  3  left-turn signal approach 1
- signal_L2  output  3  left-turn signal approach 2
- signal_L3  output  3  left-turn signal approach 3
- signal_L4  output  3  left-turn signal approach 4
- signal_pedestrian  output  1  1 = pedestrians may cross

Behaviour:
- Lamp encoding, one-hot {R,Y,G}:
  - RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001.
  - Every signal output is always exactly one of these values; never 000 or multi-hot.
- Phases, in order, with duration and non-red lamps (all other signals RED, signal_pedestrian=0 unless stated):
  - S0, T_MAIN: M1,M2 GREEN
  - S1, T_YEL: M1,M2 YELLOW
  - S2, T_LEFT: L1,L2 GREEN
  - S3, T_YEL: L1,L2 YELLOW
  - S4, T_MAIN: M3,M4 GREEN
  - S5, T_YEL: M3,M4 YELLOW
  - S6, T_LEFT: L3,L4 GREEN
  - S7, T_YEL: L3,L4 YELLOW
  - S8, T_PED: all 8 signals RED, signal_pedestrian=1
  - S8 then returns to S0.
- Timer, each rising clk edge while reset=1:
  - If count == dur(state)-1: count←0 and state←next.
  - Else count←count+1.
- Outputs are decoded combinationally from the state register only (Moore). count is the registered counter.
- Reset (reset=0, asynchronous):
  - state←S0, count←0 immediately.
  - Outputs: M1,M2 GREEN; all others RED; signal_pedestrian=0.
  - Reset asserted mid-phase aborts the phase immediately; no yellow is forced.
- After reset release, the first phase S0 lasts exactly T_MAIN edges.
- Full cycle with defaults: 7+2+5+2+7+2+5+2+5 = 37 cycles.
- Safety invariants, every cycle:
  - Never GREEN or YELLOW on a signal of group 1/2 simultaneously with any signal of group 3/4.
  - Never main and left of the same pair non-red together.
  - signal_pedestrian=1 only when all 8 signals are RED.
- Duration 1 is legal: the phase lasts one cycle and count stays 0.
- count never exceeds 31; no wrap occurs within a phase because durations are ≤32.
- Unused state encodings recover to S0 with count=0 on the next edge.

Optional Feature:
- TRAFFIC_PED_PHASE_EN
  - Defined: S8 is present as above.
  - Undefined: S7 transitions directly to S0; signal_pedestrian is tied to 0; S8 logic is not compiled. Cycle length is 32 with defaults.

Decomposition:
- Package traffic_pkg:
  - phase enum S0..S8
  - lamp constants RED/YELLOW/GREEN (3-bit)
  - function next_phase
  - function phase_duration(phase)
- One natural sub-module, phase_timer: the 5-bit counter with load-zero and terminal-count compare, producing the phase_done strobe.

Test Plan:
- Reset: drive reset=0 asynchronously mid-cycle → outputs immediately M1=M2=001, all others 100, pedestrian=0, count=0.
- Release reset, edges numbered from first edge after release (PED_EN, defaults):
  - count runs 0..6 in S0.
  - Phase entries: S1 at edge 7, S2 at 9, S3 at 14, S4 at 16, S5 at 23, S6 at 25, S7 at 30, S8 at 32, S0 again at 37.
- S8 window (edges 32–36): all 8 signals 100, signal_pedestrian=1, count 0..4.
- Run 150 cycles with an assertion monitor → one-hot encoding, conflict-free and pedestrian invariants never violated; 4 full cycles complete.
- Re-assert reset at edge 20 (in S4, count=4) → immediate S0 outputs, count=0; next S1 entry 7 edges after release.
- Build without TRAFFIC_PED_PHASE_EN → S0 re-entered at edge 32; signal_pedestrian constantly 0.
